// File: rtl/regfile_writer.sv
// regfile_writer: two-channel write-back queue feeding the register-file write port.
// Optional REGFILE_WRITER_BYPASS_EN adds a combinational query of the youngest pending write.
module regfile_writer #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int AW    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [AW-1:0]     a_idx,
    input  logic [DW-1:0]     a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [AW-1:0]     b_idx,
    input  logic [DW-1:0]     b_data,
    output logic              w_en,
    output logic [AW-1:0]     w_idx,
    output logic [DW-1:0]     w_data,
    output logic [2**AW-1:0]  pending,
    output logic              busy
`ifdef REGFILE_WRITER_BYPASS_EN
    ,
    input  logic [AW-1:0]     q_idx,
    output logic              q_hit,
    output logic [DW-1:0]     q_data
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [AW-1:0] idx_q [DEPTH];
    logic [AW-1:0] idx_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d, free;
    logic          rr_q, rr_d;
    logic          w_en_q, w_en_d;
    logic [AW-1:0] w_idx_q, w_idx_d;
    logic [DW-1:0] w_data_q, w_data_d;
    logic          a_fire, b_fire, pop, first_b;

    always_comb begin
        free    = FULL - count_q;
        a_ready = free > 1 || (free == 1 && (!b_valid || !rr_q));
        b_ready = free > 1 || (free == 1 && (!a_valid || rr_q));
        a_fire  = a_valid && a_ready;
        b_fire  = b_valid && b_ready;
        pop     = count_q != 0;
        first_b = b_fire && (!a_fire || rr_q);
        idx_d   = idx_q;
        data_d  = data_q;
        if (a_fire || b_fire) begin
            idx_d[wr_ptr_q]  = first_b ? b_idx : a_idx;
            data_d[wr_ptr_q] = first_b ? b_data : a_data;
        end
        // On a dual accept the non-preferred channel lands one slot later (younger).
        if (a_fire && b_fire) begin
            idx_d[wr_ptr_q + 1'b1]  = rr_q ? a_idx : b_idx;
            data_d[wr_ptr_q + 1'b1] = rr_q ? a_data : b_data;
        end
        wr_ptr_d = wr_ptr_q + PW'(a_fire) + PW'(b_fire);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + {{PW{1'b0}}, a_fire} + {{PW{1'b0}}, b_fire} - {{PW{1'b0}}, pop};
        rr_d     = (a_valid && b_valid && (a_fire || b_fire)) ? !rr_q : rr_q;
        w_en_d   = pop;
        w_idx_d  = pop ? idx_q[rd_ptr_q] : w_idx_q;
        w_data_d = pop ? data_q[rd_ptr_q] : w_data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= 1'b0;
            w_en_q   <= 1'b0;
            w_idx_q  <= '0;
            w_data_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            rr_q     <= rr_d;
            w_en_q   <= w_en_d;
            w_idx_q  <= w_idx_d;
            w_data_q <= w_data_d;
        end
    end

    // Storage needs no reset: the count alone decides which slots are live.
    always_ff @(posedge clk) begin
        idx_q  <= idx_d;
        data_q <= data_d;
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++)
            if ({1'b0, PW'(PW'(i) - rd_ptr_q)} < count_q)
                pending[idx_q[i]] = 1'b1;
        if (w_en_q)
            pending[w_idx_q] = 1'b1;
    end

    assign w_en   = w_en_q;
    assign w_idx  = w_idx_q;
    assign w_data = w_data_q;
    assign busy   = pop || w_en_q;

`ifdef REGFILE_WRITER_BYPASS_EN
    // Walk oldest to newest so the last match seen is the youngest one.
    always_comb begin
        q_hit  = pending[q_idx];
        q_data = (w_en_q && w_idx_q == q_idx) ? w_data_q : '0;
        for (int k = 0; k < DEPTH; k++)
            if ({1'b0, PW'(k)} < count_q && idx_q[rd_ptr_q + PW'(k)] == q_idx)
                q_data = data_q[rd_ptr_q + PW'(k)];
    end
`endif
endmodule

// File: tb/tb_regfile_writer.sv
// tb_regfile_writer: directed plus random stimulus checked against a queue-based reference model.
module tb_regfile_writer;
    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic a_valid = 1'b0, b_valid = 1'b0;
    logic a_ready, b_ready;
    logic [AW-1:0] a_idx = '0, b_idx = '0;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic w_en, busy;
    logic [AW-1:0] w_idx;
    logic [DW-1:0] w_data;
    logic [2**AW-1:0] pending;
`ifdef REGFILE_WRITER_BYPASS_EN
    logic [AW-1:0] q_idx = '0;
    logic q_hit;
    logic [DW-1:0] q_data;
`endif

    always #5 clk = ~clk;

    regfile_writer #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_idx(a_idx), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_idx(b_idx), .b_data(b_data),
        .w_en(w_en), .w_idx(w_idx), .w_data(w_data), .pending(pending), .busy(busy)
`ifdef REGFILE_WRITER_BYPASS_EN
        , .q_idx(q_idx), .q_hit(q_hit), .q_data(q_data)
`endif
    );

    int checks = 0;
    int failures = 0;
    logic [AW+DW-1:0] mq[$];
    logic m_en = 1'b0;
    logic [AW-1:0] m_idx = '0;
    logic [DW-1:0] m_data = '0;
    logic m_rr = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [2**AW-1:0] ep;
        ep = '0;
        foreach (mq[i]) ep[mq[i][AW+DW-1:DW]] = 1'b1;
        if (m_en) ep[m_idx] = 1'b1;
        check("w_en", w_en, m_en);
        check("w_idx", w_idx, m_idx);
        check("w_data", w_data, m_data);
        check("pending", pending, ep);
        check("busy", busy, mq.size() > 0 || m_en);
`ifdef REGFILE_WRITER_BYPASS_EN
        begin
            logic eh;
            logic [DW-1:0] ed;
            eh = 1'b0;
            ed = '0;
            if (m_en && m_idx == q_idx) begin eh = 1'b1; ed = m_data; end
            foreach (mq[i])
                if (mq[i][AW+DW-1:DW] == q_idx) begin eh = 1'b1; ed = mq[i][DW-1:0]; end
            check("q_hit", q_hit, eh);
            check("q_data", q_data, ed);
        end
`endif
    endtask

    // One cycle: drive inputs, check readiness before the edge, advance model, check outputs after.
    task automatic step(input logic av, input logic [AW-1:0] ai, input logic [DW-1:0] ad,
                        input logic bv, input logic [AW-1:0] bi, input logic [DW-1:0] bd);
        int free;
        logic ea, eb, fa, fb;
        a_valid = av; a_idx = ai; a_data = ad;
        b_valid = bv; b_idx = bi; b_data = bd;
`ifdef REGFILE_WRITER_BYPASS_EN
        q_idx = AW'($urandom_range(0, 7));
`endif
        #1;
        free = DEPTH - mq.size();
        ea = free >= 2 || (free == 1 && (!bv || !m_rr));
        eb = free >= 2 || (free == 1 && (!av || m_rr));
        check("a_ready", a_ready, ea);
        check("b_ready", b_ready, eb);
        fa = av && ea;
        fb = bv && eb;
        @(posedge clk);
        #1;
        if (mq.size() > 0) begin
            {m_idx, m_data} = mq.pop_front();
            m_en = 1'b1;
        end else m_en = 1'b0;
        if (fa && fb) begin
            if (m_rr) begin mq.push_back({bi, bd}); mq.push_back({ai, ad}); end
            else begin mq.push_back({ai, ad}); mq.push_back({bi, bd}); end
        end else if (fa) mq.push_back({ai, ad});
        else if (fb) mq.push_back({bi, bd});
        if (av && bv && (fa || fb)) m_rr = !m_rr;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        #12;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();
        check("reset_pending", pending, 0);
        // single write
        step(1'b1, 5'd3, 16'h1234, 1'b0, '0, '0);
        check("single_pending3", pending[3], 1'b1);
        step(1'b0, '0, '0, 1'b0, '0, '0);
        check("single_w_idx", w_idx, 3);
        check("single_w_data", w_data, 16'h1234);
        idle(2);
        check("single_busy_low", busy, 1'b0);
        // dual accept, A preferred first
        step(1'b1, 5'd1, 16'hAAAA, 1'b1, 5'd2, 16'hBBBB);
        step(1'b0, '0, '0, 1'b0, '0, '0);
        check("dual_first", w_data, 16'hAAAA);
        step(1'b0, '0, '0, 1'b0, '0, '0);
        check("dual_second", w_data, 16'hBBBB);
        idle(2);
        // duplicate index
        step(1'b1, 5'd7, 16'h0001, 1'b0, '0, '0);
        step(1'b1, 5'd7, 16'h0002, 1'b0, '0, '0);
        idle(4);
        check("dup_final", w_data, 16'h0002);
        // fill / backpressure
        for (int i = 0; i < 12; i++)
            step(1'b1, AW'(i), DW'(16'hA000 + i), 1'b1, AW'(i + 16), DW'(16'hB000 + i));
        idle(6);
        // reset with entries queued
        step(1'b1, 5'd4, 16'h4444, 1'b1, 5'd5, 16'h5555);
        step(1'b1, 5'd6, 16'h6666, 1'b1, 5'd8, 16'h8888);
        check("pre_reset_busy", busy, 1'b1);
        a_valid = 1'b0;
        b_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        mq.delete();
        m_en = 1'b0; m_idx = '0; m_data = '0; m_rr = 1'b0;
        check("rst_w_en", w_en, 1'b0);
        check("rst_pending", pending, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_a_ready", a_ready, 1'b1);
        check("rst_b_ready", b_ready, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();
        idle(3);
        // random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), DW'($urandom),
                 $urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), DW'($urandom));
        idle(6);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_writer.md
# regfile_writer

Write-back collector for the 32×16 register file: accepts results from two producers (ALU channel A, load/store channel B) over valid/ready handshakes, buffers them in an in-order queue, and drives the register file's single write port (`w_en`/`w_idx`/`w_data`) at one write per cycle. It also exports a pending-write mask so operand-read logic can detect read-after-write hazards against queued results.

## Interface
- `DEPTH`, 4, queue entries; power of two, 2..16
- `DW`, 16, data width; matches register word
- `AW`, 5, register index width
- `clk` in 1 clock, all state on rising edge
- `reset` in 1 asynchronous, active-low
- `a_valid` in 1 channel A result valid
- `a_ready` out 1 channel A accepted this cycle (combinational)
- `a_idx` in AW channel A destination register
- `a_data` in DW channel A result
- `b_valid`, `b_ready`, `b_idx`, `b_data`: same as channel A, for channel B
- `w_en` out 1 register-file write enable (registered)
- `w_idx` out AW register-file write index (registered)
- `w_data` out DW register-file write data (registered)
- `pending` out 2^AW bit i set while any queued or output-stage write targets register i
- `busy` out 1 queue non-empty or `w_en` high
- `q_idx` in AW bypass query index (only with `REGFILE_WRITER_BYPASS_EN`)
- `q_hit` out 1 query matches a pending write (only with macro)
- `q_data` out DW youngest pending data for `q_idx` (only with macro)

## Operation
- Queue: circular buffer, `DEPTH` entries, read/write pointers plus count (`log2(DEPTH)+1` bits). `free = DEPTH − count`, sampled before the edge.
- Enqueue: up to two entries per cycle. Transfer on a channel = `valid && ready` at a rising edge.
- Ready rules, `rr` = round-robin flag (0 prefers A):
  - `a_ready = free>=2 || (free==1 && (!b_valid || rr==0))`; `b_ready` symmetric with `rr==1`.
  - `free==0`: both ready low. A pop in the same cycle does not create space for that cycle.
- Ordering: when both transfer in one cycle, the `rr`-preferred entry is written first (older). `rr` flips whenever both channels are valid and at least one transfers. `rr` is unchanged otherwise.
- Drain: every cycle the queue is non-empty at the edge, the head is popped into the output register: `w_en<=1`, `w_idx/w_data<=head`. With an empty queue: `w_en<=0`, and `w_idx/w_data` hold their values.
- No write suppression: index 0 is written like any other index. Duplicate indices are written in queue order.
- `pending`: OR of one-hot(`idx`) over valid queue entries and the output stage while `w_en=1`. Combinational from state. A bit clears only after the last write to that register leaves the output stage.
- Reset (any time, including mid-burst): queued writes are discarded; pointers, count, `rr` = 0; `w_en`=0, `w_idx`=0, `w_data`=0. This gives `pending`=0, `busy`=0, `a_ready`=`b_ready`=1.

## Timing
- A result accepted at edge k with an empty queue: popped at k+1, `w_en` high during cycle k+1→k+2, register file writes at edge k+2.
- Sustained throughput is one write per cycle. The enqueue burst rate is 2 per cycle until full.
- `pending[i]` rises in the cycle after the accepting edge. It falls in the cycle after `w_en` for the last matching write drops.
- Ready depends combinationally on the other channel's valid. Producers must not make valid depend on ready.

## Configuration
- `REGFILE_WRITER_BYPASS_EN` defined: `q_idx`/`q_hit`/`q_data` exist.
  - `q_hit`=1 iff `pending[q_idx]`.
  - `q_data` is taken from the youngest match: the newest queue entry, else the output stage.
  - `q_data`=0 when there is no hit. Lookup is purely combinational.
- Macro undefined: the three ports and the match logic are absent; all other behaviour is identical.

## Test plan
- Single write: after reset, A sends idx 3 / 0x1234 at edge k → `w_en`=1, `w_idx`=3, `w_data`=0x1234 for exactly cycle k+1→k+2; `pending[3]` high from k to k+2; `busy` low afterwards.
- Dual accept ordering: empty queue, rr=0, A (idx 1, 0xAAAA) and B (idx 2, 0xBBBB) both valid for one cycle → both ready; writes appear A then B on consecutive cycles; rr=1 afterwards.
- Fill/backpressure, DEPTH=4: A and B valid continuously → accepts 2, 2, then `free==1` alternates grants by rr, with one write drained per cycle; no ready high while `free==0`; output sequence matches grant order with no loss or duplication.
- Duplicate index: A writes idx 7 = 0x0001, then idx 7 = 0x0002 → `pending[7]` stays high until the second write leaves the output stage; with the macro, `q_idx`=7 returns 0x0002 while both are pending; final write is 0x0002.
- Reset mid-operation: queue holding 3 entries, assert `reset` low asynchronously → `w_en`, `pending`, `busy` go 0 immediately; after release, no stale writes appear.
- Build without `REGFILE_WRITER_BYPASS_EN`: repeat test 3 → identical write trace.
